// File: rtl/aes_pkg.sv
// Shared AES helpers: key-length encodings, Nk/Nr lookup, xtime and the S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic key_len_legal(input logic [1:0] kl);
    logic ok;
    ok = (kl != KL_BAD);
    return ok;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] nk;
    case (kl)
      KL_128:  nk = 4'd4;
      KL_192:  nk = 4'd6;
      KL_256:  nk = 4'd8;
      default: nk = 4'd0;
    endcase
    return nk;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      KL_128:  nr = 4'd10;
      KL_192:  nr = 4'd12;
      KL_256:  nr = 4'd14;
      default: nr = 4'd0;
    endcase
    return nr;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int unsigned idx;
    idx = 32'd255 - 32'(b);
    return SBOX_TBL[8*idx +: 8];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [31:0] w_sub;

  always_comb begin
    w_sub = '0;
    for (int b = 0; b < 4; b++) begin
      w_sub[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end
  end

  assign o_word = w_sub;

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one word per clock into a schedule
// buffer, with a zero-latency 128-bit round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  key_valid,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_out
);

  localparam int unsigned NW = 4 * (MAX_NK + 7);
  localparam int unsigned IW = $clog2(NW);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e        r_state;
  logic [31:0]   r_w [NW];
  logic [IW-1:0] r_i;
  logic [3:0]    r_j;
  logic [7:0]    r_rcon;
  logic [3:0]    r_nk;
  logic [3:0]    r_nr;

  logic [3:0]    w_nk_in;
  logic          w_accept;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic          w_last;
  logic [5:0]    w_rk_base;

  assign w_nk_in  = nk_of(key_len);
  assign w_accept = start && key_len_legal(key_len) && (32'(w_nk_in) <= MAX_NK);

  // Recurrence inputs: w[i-1] and w[i-Nk]
  assign w_prev   = r_w[r_i - IW'(1)];
  assign w_back   = r_w[r_i - IW'(r_nk)];
  assign w_sub_in = (r_j == 4'd0) ? {w_prev[7:0], w_prev[31:8]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_j == 4'd0) begin
      w_temp = w_sub_out ^ {24'h000000, r_rcon};
    end else if ((r_nk == 4'd8) && (r_j == 4'd4)) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new  = w_back ^ w_temp;
  assign w_last = (r_i == IW'({r_nr, 2'b00} + 6'd3));

  // Control FSM with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_rcon    <= RCON_INIT;
      r_nk      <= '0;
      r_nr      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_accept) begin
              r_state   <= ST_EXPAND;
              busy      <= 1'b1;
              key_valid <= 1'b0;
              r_nk      <= w_nk_in;
              r_nr      <= nr_of(key_len);
              r_i       <= IW'(w_nk_in);
              r_j       <= 4'd0;
              r_rcon    <= RCON_INIT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_EXPAND: begin
          r_i <= r_i + IW'(1);
          r_j <= (r_j == r_nk - 4'd1) ? 4'd0 : r_j + 4'd1;
          if (r_j == 4'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          key_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Schedule buffer: key words on acceptance, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && w_accept) begin
      for (int unsigned k = 0; k < MAX_NK; k++) begin
        if (k < 32'(w_nk_in)) begin
          r_w[IW'(k)] <= key_in[32*k +: 32];
        end
      end
    end else if (r_state == ST_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  assign w_rk_base = {rk_idx, 2'b00};

  always_comb begin
    rk_out = '0;
    if (key_valid && (rk_idx <= r_nr)) begin
      rk_out = {r_w[IW'(w_rk_base + 6'd3)], r_w[IW'(w_rk_base + 6'd2)],
                r_w[IW'(w_rk_base + 6'd1)], r_w[IW'(w_rk_base)]};
    end
  end

endmodule
